// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port (I/D cache) memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_I = 2'b01,
    GRANT_D = 2'b10
  } arb_state_e;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational 2-way round-robin picker: ties go to the side not granted last.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req_I,
  input  logic req_D,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = req_I | req_D;
    if (req_I && req_D)
      gnt_id = ~last_grant;
    else if (req_D)
      gnt_id = GNT_D;
    else
      gnt_id = GNT_I;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one block memory port between I-cache and D-cache; one atomic
// transaction at a time with a guaranteed idle command cycle between them.
module mem_arbiter #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read_I,
  input  logic              mem_write_I,
  input  logic [ADDR_W-1:0] mem_addr_I,
  input  logic [DATA_W-1:0] mem_wdata_I,
  output logic [DATA_W-1:0] mem_rdata_I,
  output logic              mem_ready_I,
  input  logic              mem_read_D,
  input  logic              mem_write_D,
  input  logic [ADDR_W-1:0] mem_addr_D,
  input  logic [DATA_W-1:0] mem_wdata_D,
  output logic [DATA_W-1:0] mem_rdata_D,
  output logic              mem_ready_D,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);
  import mem_arb_pkg::*;

  arb_state_e        state;
  logic              last_grant;
  logic              req_I, req_D;
  logic              gnt_valid, gnt_id;
  logic              sel_rd, sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req_I = mem_read_I | mem_write_I;
  assign req_D = mem_read_D | mem_write_D;

  mem_arb_pick u_pick (
    .req_I      (req_I),
    .req_D      (req_D),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    if (gnt_id == GNT_D) begin
      sel_rd    = mem_read_D;
      sel_wr    = mem_write_D;
      sel_addr  = mem_addr_D;
      sel_wdata = mem_wdata_D;
    end else begin
      sel_rd    = mem_read_I;
      sel_wr    = mem_write_I;
      sel_addr  = mem_addr_I;
      sel_wdata = mem_wdata_I;
    end
  end

  // Command is captured once on grant and frozen until memory completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= GNT_I;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            state      <= (gnt_id == GNT_D) ? GRANT_D : GRANT_I;
            last_grant <= gnt_id;
            mem_write  <= sel_wr;
            mem_read   <= sel_rd & ~sel_wr;  // illegal rd+wr: write wins
            mem_addr   <= sel_addr;
            mem_wdata  <= sel_wdata;
          end
        end
        GRANT_I, GRANT_D: begin
          if (mem_ready) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

  // Ready is forwarded same-cycle to the owner only; a stray ready in IDLE dies here.
  assign mem_ready_I = (state == GRANT_I) & mem_ready;
  assign mem_ready_D = (state == GRANT_D) & mem_ready;
  assign mem_rdata_I = mem_rdata;
  assign mem_rdata_D = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level model checked every cycle,
// plus literal checks on grant order, latency, gaps and reset behaviour.
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          rd_c[2], wr_c[2];
  logic [AW-1:0] addr_c[2];
  logic [DW-1:0] wd_c[2];
  logic [DW-1:0] rdata_I, rdata_D, mem_wdata, mem_rdata;
  logic          rdy_I, rdy_D, mem_read, mem_write, mem_ready;
  logic [AW-1:0] mem_addr;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_I(rd_c[0]), .mem_write_I(wr_c[0]), .mem_addr_I(addr_c[0]),
    .mem_wdata_I(wd_c[0]), .mem_rdata_I(rdata_I), .mem_ready_I(rdy_I),
    .mem_read_D(rd_c[1]), .mem_write_D(wr_c[1]), .mem_addr_D(addr_c[1]),
    .mem_wdata_D(wd_c[1]), .mem_rdata_D(rdata_D), .mem_ready_D(rdy_D),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct {logic rd; logic wr; logic [AW-1:0] a; logic [DW-1:0] d;} req_t;
  req_t q_I[$], q_D[$];
  bit   busy[2];
  bit   flush, stale;
  int   cyc, lat, asrt, fails;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    asrt++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level model: who owns the port, and what command it issued.
  int            m_own;   // 0 none, 1 I, 2 D
  bit            m_last_d;
  logic          m_rd, m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  int            pend;

  function automatic int pick_side(logic pi, logic pd, bit lastd);
    if (pi && pd) return lastd ? 1 : 2;
    if (pd) return 2;
    if (pi) return 1;
    return 0;
  endfunction

  always_comb pend = pick_side(rd_c[0] | wr_c[0], rd_c[1] | wr_c[1], m_last_d);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_own <= 0; m_last_d <= 1'b0; m_rd <= 1'b0; m_wr <= 1'b0; m_addr <= '0; m_wd <= '0;
    end else if (m_own == 0) begin
      if (pend != 0) begin
        m_own    <= pend;
        m_last_d <= (pend == 2);
        m_wr     <= wr_c[pend-1];
        m_rd     <= rd_c[pend-1] && !wr_c[pend-1];
        m_addr   <= addr_c[pend-1];
        m_wd     <= wd_c[pend-1];
      end
    end else if (mem_ready) begin
      m_own <= 0; m_rd <= 1'b0; m_wr <= 1'b0;
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    chk("cmd", {mem_read, mem_write, mem_addr, mem_wdata}, {m_rd, m_wr, m_addr, m_wd});
    chk("ready", {rdy_I, rdy_D}, {(m_own == 1) && mem_ready, (m_own == 2) && mem_ready});
    chk("rdata", {rdata_I, rdata_D}, {mem_rdata, mem_rdata});
  end

  // Cache drivers: present queued requests, hold until ready, then next.
  initial begin : drv
    bit s0, s1;
    req_t r;
    forever begin
      @(negedge clk); s0 = rdy_I; s1 = rdy_D;
      @(posedge clk); #1;
      if (flush) begin
        q_I.delete(); q_D.delete(); busy[0] = 0; busy[1] = 0;
        rd_c[0] = 0; wr_c[0] = 0; rd_c[1] = 0; wr_c[1] = 0; flush = 0;
      end else begin
        if (s0) begin busy[0] = 0; rd_c[0] = 0; wr_c[0] = 0; end
        if (s1) begin busy[1] = 0; rd_c[1] = 0; wr_c[1] = 0; end
        if (!busy[0] && q_I.size() > 0) begin
          r = q_I.pop_front();
          rd_c[0] = r.rd; wr_c[0] = r.wr; addr_c[0] = r.a; wd_c[0] = r.d; busy[0] = 1;
        end
        if (!busy[1] && q_D.size() > 0) begin
          r = q_D.pop_front();
          rd_c[1] = r.rd; wr_c[1] = r.wr; addr_c[1] = r.a; wd_c[1] = r.d; busy[1] = 1;
        end
      end
    end
  end

  // Memory: ready one-cycle pulse after lat cycles of command.
  initial begin : memm
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin mem_ready = 0; cnt = 0; end
      else if (mem_ready) mem_ready = 0;
      else if (stale) begin mem_ready = 1; mem_rdata = 128'hBAD; stale = 0; end
      else if (mem_read | mem_write) begin
        cnt++;
        if (cnt >= lat) begin
          mem_ready = 1; cnt = 0;
          mem_rdata = {4{4'hA, mem_addr}};
        end
      end else cnt = 0;
    end
  end

  // Command log for order/gap checks.
  int            st_cyc[$], en_cyc[$];
  logic [AW-1:0] st_addr[$];
  bit            st_rd[$], st_wr[$];
  logic [DW-1:0] st_wd[$];
  int            moved, n_rdy_I, n_rdy_D;
  logic [DW-1:0] last_rdI;

  initial begin : logger
    bit p_act, act;
    p_act = 0;
    forever begin
      @(negedge clk);
      act = mem_read | mem_write;
      if (act && !p_act) begin
        st_cyc.push_back(cyc); st_addr.push_back(mem_addr);
        st_rd.push_back(mem_read); st_wr.push_back(mem_write); st_wd.push_back(mem_wdata);
      end else if (act && mem_addr != st_addr[$]) moved++;
      if (!act && p_act) en_cyc.push_back(cyc);
      p_act = act;
      if (rdy_I) begin n_rdy_I++; last_rdI = rdata_I; end
      if (rdy_D) n_rdy_D++;
    end
  end

  task automatic clr_log();
    st_cyc.delete(); en_cyc.delete(); st_addr.delete();
    st_rd.delete(); st_wr.delete(); st_wd.delete();
    moved = 0; n_rdy_I = 0; n_rdy_D = 0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while ((q_I.size() > 0 || q_D.size() > 0 || busy[0] || busy[1] || mem_read || mem_write)
               && n < budget);
    if (n >= budget) chk({nm, "_timeout"}, 1, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_cmd(input int budget, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(mem_read | mem_write) && n < budget);
    if (n >= budget) chk({nm, "_nocmd"}, 1, 0);
  endtask

  localparam logic [DW-1:0] DIRTY = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;

  initial begin : main
    int k;
    rst_n = 0; flush = 0; stale = 0; lat = 4; asrt = 0; fails = 0; cyc = 0;
    for (int i = 0; i < 2; i++) begin rd_c[i] = 0; wr_c[i] = 0; addr_c[i] = '0; wd_c[i] = '0; end
    mem_ready = 0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {mem_read, mem_write, mem_addr, mem_wdata, rdy_I, rdy_D}, 0);
    rst_n = 1;
    @(negedge clk);

    // I-only read, memory latency 4
    clr_log(); lat = 4; k = cyc;
    q_I.push_back('{1'b1, 1'b0, 28'h0000100, '0});
    wait_done(60, "t1");
    chk("t1_ncmd", st_addr.size(), 1);
    chk("t1_addr", {st_rd[0], st_wr[0], st_addr[0]}, {1'b1, 1'b0, 28'h0000100});
    chk("t1_latency", st_cyc[0], k + 2);
    chk("t1_len", en_cyc[0] - st_cyc[0], 4);
    chk("t1_rdy", {n_rdy_I[7:0], n_rdy_D[7:0]}, 16'h0100);
    chk("t1_rdata", last_rdI, 128'hA0000100_A0000100_A0000100_A0000100);

    // Tie after an I grant: D first, then I, one idle cycle between
    clr_log(); lat = 3;
    q_I.push_back('{1'b1, 1'b0, 28'h0000200, '0});
    q_D.push_back('{1'b1, 1'b0, 28'h0000300, '0});
    wait_done(60, "t2");
    chk("t2_order", {st_addr[0], st_addr[1]}, {28'h0000300, 28'h0000200});
    chk("t2_gap", st_cyc[1] - en_cyc[0], 1);
    chk("t2_rdy", {n_rdy_I[7:0], n_rdy_D[7:0]}, 16'h0101);
    // D alone, then a tie goes to I
    clr_log(); lat = 2;
    q_D.push_back('{1'b1, 1'b0, 28'h0000310, '0});
    wait_done(60, "t2b");
    clr_log();
    q_I.push_back('{1'b1, 1'b0, 28'h0000220, '0});
    q_D.push_back('{1'b1, 1'b0, 28'h0000320, '0});
    wait_done(60, "t2c");
    chk("t2_tie_I", {st_addr[0], st_addr[1]}, {28'h0000220, 28'h0000320});

    // Dirty eviction on D with I arriving during the write-back
    clr_log(); lat = 3;
    q_D.push_back('{1'b0, 1'b1, 28'h0000400, DIRTY});
    q_D.push_back('{1'b1, 1'b0, 28'h0000400, '0});
    wait_cmd(20, "t3");
    q_I.push_back('{1'b1, 1'b0, 28'h0000500, '0});
    wait_done(80, "t3");
    chk("t3_ncmd", st_addr.size(), 3);
    chk("t3_wb", {st_wr[0], st_rd[0], st_addr[0], st_wd[0]}, {1'b1, 1'b0, 28'h0000400, DIRTY});
    chk("t3_order", {st_addr[1], st_rd[1], st_addr[2], st_rd[2]},
        {28'h0000500, 1'b1, 28'h0000400, 1'b1});
    chk("t3_gap1", st_cyc[1] - en_cyc[0], 1);
    chk("t3_gap2", st_cyc[2] - en_cyc[1], 1);

    // Cache address changes mid-grant
    clr_log(); lat = 5;
    q_I.push_back('{1'b1, 1'b0, 28'h0000010, '0});
    wait_cmd(20, "t4");
    addr_c[0] = 28'h0000020;
    wait_done(60, "t4");
    chk("t4_addr", st_addr[0], 28'h0000010);
    chk("t4_held", moved, 0);

    // Read and write together: write wins
    clr_log(); lat = 2;
    q_I.push_back('{1'b1, 1'b1, 28'h0000030, 128'h5555});
    wait_done(60, "t5");
    chk("t5_wr_wins", {st_wr[0], st_rd[0], st_wd[0]}, {1'b1, 1'b0, 128'h5555});

    // Reset while D waits on memory
    clr_log(); lat = 8;
    q_D.push_back('{1'b1, 1'b0, 28'h0000700, '0});
    wait_cmd(20, "t6");
    @(negedge clk);
    chk("t6_granted", {mem_read, mem_addr}, {1'b1, 28'h0000700});
    #2 rst_n = 0; flush = 1;
    #1 chk("t6_async_clr", {mem_read, mem_write, mem_addr, mem_wdata, rdy_I, rdy_D}, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    clr_log();
    stale = 1;
    @(negedge clk);
    chk("t6_stale_pulse", mem_ready, 1);
    chk("t6_stale_blocked", {rdy_I, rdy_D}, 0);
    @(negedge clk);
    lat = 2;
    q_D.push_back('{1'b1, 1'b0, 28'h0000710, '0});
    wait_done(60, "t6");
    chk("t6_regrant", {st_addr.size(), st_addr[0]}, {32'd1, 28'h0000710});
    chk("t6_rdy", {n_rdy_I[7:0], n_rdy_D[7:0]}, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", asrt, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one slow off-chip memory port between the instruction cache and the data cache. It sits between the two `cache` instances and a single memory model, presenting each cache with the same block interface it would see from a private memory. Grants are round-robin on ties, and the block guarantees a one-cycle command gap between transactions. Every transaction completes atomically, including a D-side write-back.

## Interface
Parameters:
- ADDR_W, 28, block address width (byte address bits [31:4])
- DATA_W, 128, block data width

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock
  - rst_n  in  1  asynchronous active-low reset
- I-cache side:
  - mem_read_I  in  1  I-cache read request
  - mem_write_I  in  1  I-cache write request
  - mem_addr_I  in  ADDR_W  I-cache block address
  - mem_wdata_I  in  DATA_W  I-cache write block
  - mem_rdata_I  out  DATA_W  read block to I-cache
  - mem_ready_I  out  1  completion pulse to I-cache
- D-cache side (same meanings as the I-cache side):
  - mem_read_D  in  1
  - mem_write_D  in  1
  - mem_addr_D  in  ADDR_W
  - mem_wdata_D  in  DATA_W
  - mem_rdata_D  out  DATA_W
  - mem_ready_D  out  1
- Memory side:
  - mem_read  out  1  read command
  - mem_write  out  1  write command
  - mem_addr  out  ADDR_W  block address
  - mem_wdata  out  DATA_W  write block
  - mem_rdata  in  DATA_W  read block
  - mem_ready  in  1  completion pulse from memory, one cycle wide

## Operation
- A cache request is pending when its read or write line is high.
  - Each cache holds its request, address and wdata stable until it sees its ready.
- State machine: IDLE, GRANT_I, GRANT_D.
  - IDLE, no request pending: stay in IDLE.
  - IDLE, only one side pending: go to that side's GRANT state.
  - IDLE, both sides pending: grant the side not granted last. `last_grant` resets to I, so the first tie goes to D.
  - On entering a GRANT state, register mem_read, mem_write, mem_addr and mem_wdata from the granted side and update `last_grant`.
- Read and write asserted together by one side is illegal. The write wins: mem_write=1, mem_read=0.
- While in GRANT_x:
  - Memory outputs are held constant; later changes on the cache inputs are ignored.
  - mem_ready_x = mem_ready, combinational, same cycle. The non-granted side's ready is 0.
  - When mem_ready=1, go to IDLE and clear mem_read and mem_write at that edge.
- mem_rdata_I and mem_rdata_D are both wired directly to mem_rdata. Only ready is gated.
- A mem_ready arriving in IDLE is ignored; no cache sees it.
- Transactions are atomic. A D-side dirty eviction (write then read) is two transactions. The I side may be granted between them if it is pending at the intervening IDLE sample and `last_grant` is D.
- Reset values:
  - state=IDLE, last_grant=I.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - mem_ready_I=0, mem_ready_D=0.
- Reset asserted mid-transaction: the transaction is abandoned, all outputs return to reset values immediately, and no ready is forwarded.

## Timing
- Grant latency: a request high at edge N puts the command on the memory port from cycle N+1. There is no combinational path from cache inputs to memory outputs.
- Completion: mem_ready in cycle M gives the granted side's ready in cycle M with valid mem_rdata.
  - The memory command is low in cycle M+1 (IDLE).
  - The earliest next command is cycle M+2.
- Back-to-back transactions therefore always have exactly one idle cycle with mem_read=mem_write=0 between them.
- A request that goes high while the other side is granted is served at the first IDLE sample. Worst-case wait is one full transaction of the other side plus 2 cycles.

## Structure
- Shared package `mem_arb_pkg`:
  - State encoding: IDLE=2'b00, GRANT_I=2'b01, GRANT_D=2'b10.
  - Grant-ID constants GNT_I=1'b0, GNT_D=1'b1.
  - Default widths ADDR_W and DATA_W.
- One sub-module, `mem_arb_pick`: a combinational 2-way round-robin picker.
  - Inputs: req_I, req_D, last_grant.
  - Outputs: gnt_valid, gnt_id.
- The FSM, the output registers and `last_grant` live in mem_arbiter.

## Test plan
- Reset, then I-only read to 0x0000100 with memory ready 4 cycles later:
  - mem_read=1 and mem_addr=0x0000100 one cycle after the request.
  - mem_ready_I pulses once with rdata; mem_ready_D stays 0.
  - mem_read=0 the following cycle.
- Both sides request at the same edge after reset: D is granted first and I is granted next.
  - Command gap between the two transactions is exactly 1 cycle.
  - The next tie goes to I.
- D dirty miss with I pending: the order is D write (wdata=0xDEAD…BEEF passed through), then I read, then D read.
  - Each transaction is separated by one idle cycle.
- Cache inputs change in the middle of a grant (addr 0x10→0x20): mem_addr stays 0x10 until ready.
- Read and write asserted together on I: the memory sees mem_write=1, mem_read=0.
- rst_n asserted while GRANT_D is waiting: all outputs go to 0 immediately.
  - After release, the next request is granted normally and a stale mem_ready in IDLE produces no cache ready.
